// File: rtl/siso_ctrl_pkg.sv
// Shared state encoding and frame geometry for the SISO loopback sequencer.
package siso_ctrl_pkg;

   localparam int SISO_DEPTH   = 8;
   localparam int FRAME_SHIFTS = 2 * SISO_DEPTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } siso_ctrl_state_t;

endpackage

// File: rtl/siso_ctrl_bit_counter.sv
// Shift-slot counter for one loopback frame, advanced only on shift edges.
// Latency: count and terminal flags are registered, valid the cycle after the edge.
// Backpressure: none; a held frame simply leaves en low.
module siso_bit_counter #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 en,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 cnt_is_load_last,
   output logic                 cnt_is_frame_last
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign cnt_is_load_last  = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));
   assign cnt_is_frame_last = (cnt == CNT_WIDTH'(2 * DATA_WIDTH - 1));

endmodule

// File: rtl/siso_8_bit_loopback_controller.sv
// Loopback self-test sequencer: loads a byte MSB-first into a SISO register, flushes it back out and compares.
// Latency: Rx_Valid_Out rises 2*DATA_WIDTH cycles after accept, plus one per held shift slot.
// Backpressure: Tx_Ready_Out only in IDLE; result held in DONE until Rx_Ready_In.
module siso_8_bit_loopback_controller
   import siso_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = SISO_DEPTH,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  Clk_In,
   input  logic                  Reset_In,
   input  logic [DATA_WIDTH-1:0] Tx_Data_In,
   input  logic                  Tx_Valid_In,
   output logic                  Tx_Ready_Out,
   input  logic                  Hold_In,
   output logic [DATA_WIDTH-1:0] Rx_Data_Out,
   output logic                  Rx_Valid_Out,
   input  logic                  Rx_Ready_In,
   output logic                  Error_Out,
   output logic                  Busy_Out,
   output logic                  SR_Enable_Out,
   output logic                  SR_Shift_Out,
   output logic                  SR_Serial_Data_Out,
   input  logic                  SR_Serial_Data_In
);

   localparam int IDX_W = $clog2(DATA_WIDTH);
   localparam int FRAME = 2 * DATA_WIDTH;

   siso_ctrl_state_t state_q, state_d;

   logic [DATA_WIDTH-1:0] tx_byte_q, tx_byte_d;
   logic [DATA_WIDTH-1:0] rx_byte_q, rx_byte_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_vld_q, rx_vld_d;
   logic                  err_q, err_d;
   logic                  sr_en_q, sr_en_d;
   logic                  sr_shift_q, sr_shift_d;
   logic                  sr_ser_q, sr_ser_d;

   logic [CNT_WIDTH-1:0]  cnt;
   logic [CNT_WIDTH-1:0]  cnt_after;
   logic                  cnt_is_load_last;
   logic                  cnt_is_frame_last;
   logic                  cnt_clr;
   logic                  cnt_en;
   logic                  shift_edge;
   logic                  in_frame;
   logic [IDX_W-1:0]      load_idx;
   logic [DATA_WIDTH-1:0] rx_shifted;

   // A shift edge is any edge at which the register was told to shift.
   assign shift_edge = sr_shift_q;
   assign in_frame   = (state_q == LOAD) || (state_q == FLUSH);
   assign cnt_clr    = (state_q == IDLE) && Tx_Valid_In;
   assign cnt_en     = shift_edge && in_frame;
   assign cnt_after  = shift_edge ? (cnt + 1'b1) : cnt;

   // Bit to present after shift edge n is tx_byte[DATA_WIDTH-2-n].
   assign load_idx   = IDX_W'(DATA_WIDTH - 2) - cnt[IDX_W-1:0];
   assign rx_shifted = {rx_byte_q[DATA_WIDTH-2:0], SR_Serial_Data_In};

   siso_bit_counter #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_bit_counter (
      .clk               (Clk_In),
      .rst_n             (Reset_In),
      .clr               (cnt_clr),
      .en                (cnt_en),
      .cnt               (cnt),
      .cnt_is_load_last  (cnt_is_load_last),
      .cnt_is_frame_last (cnt_is_frame_last)
   );

   always_comb begin
      state_d    = state_q;
      tx_byte_d  = tx_byte_q;
      rx_byte_d  = rx_byte_q;
      rx_data_d  = rx_data_q;
      rx_vld_d   = rx_vld_q;
      err_d      = err_q;
      sr_en_d    = sr_en_q;
      sr_shift_d = sr_shift_q;
      sr_ser_d   = sr_ser_q;

      unique case (state_q)
         IDLE: begin
            sr_en_d    = 1'b0;
            sr_shift_d = 1'b0;
            if (Tx_Valid_In) begin
               tx_byte_d  = Tx_Data_In;
               sr_en_d    = 1'b1;
               sr_shift_d = !Hold_In;
               sr_ser_d   = Tx_Data_In[DATA_WIDTH-1];
               state_d    = LOAD;
            end
         end

         LOAD: begin
            sr_shift_d = !Hold_In && (cnt_after < CNT_WIDTH'(FRAME));
            if (shift_edge) begin
               if (cnt_is_load_last) begin
                  sr_ser_d = 1'b0;
                  state_d  = FLUSH;
               end else begin
                  sr_ser_d = tx_byte_q[load_idx];
               end
            end
         end

         FLUSH: begin
            sr_ser_d   = 1'b0;
            sr_shift_d = !Hold_In && (cnt_after < CNT_WIDTH'(FRAME));
            // The register MSB is sampled before this edge's shift moves it out.
            if (shift_edge) begin
               rx_byte_d = rx_shifted;
               if (cnt_is_frame_last) begin
                  rx_data_d  = rx_shifted;
                  rx_vld_d   = 1'b1;
                  err_d      = (rx_shifted != tx_byte_q);
                  sr_shift_d = 1'b0;
                  sr_en_d    = 1'b0;
                  state_d    = DONE;
               end
            end
         end

         DONE: begin
            sr_shift_d = 1'b0;
            sr_en_d    = 1'b0;
            if (Rx_Ready_In) begin
               rx_vld_d = 1'b0;
               err_d    = 1'b0;
               state_d  = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk_In or negedge Reset_In) begin
      if (!Reset_In) begin
         state_q    <= IDLE;
         tx_byte_q  <= '0;
         rx_byte_q  <= '0;
         rx_data_q  <= '0;
         rx_vld_q   <= 1'b0;
         err_q      <= 1'b0;
         sr_en_q    <= 1'b0;
         sr_shift_q <= 1'b0;
         sr_ser_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_byte_q  <= tx_byte_d;
         rx_byte_q  <= rx_byte_d;
         rx_data_q  <= rx_data_d;
         rx_vld_q   <= rx_vld_d;
         err_q      <= err_d;
         sr_en_q    <= sr_en_d;
         sr_shift_q <= sr_shift_d;
         sr_ser_q   <= sr_ser_d;
      end
   end

   assign Tx_Ready_Out       = (state_q == IDLE);
   assign Busy_Out           = in_frame;
   assign Rx_Data_Out        = rx_data_q;
   assign Rx_Valid_Out       = rx_vld_q;
   assign Error_Out          = err_q;
   assign SR_Enable_Out      = sr_en_q;
   assign SR_Shift_Out       = sr_shift_q;
   assign SR_Serial_Data_Out = sr_ser_q;

endmodule

// File: doc/siso_8_bit_loopback_controller.md
Name: siso_8_bit_loopback_controller

Overview:
Sequencing controller for the 8-bit serial-in/serial-out shift register.
- Accepts a parallel byte over a valid/ready handshake and shifts it MSB-first into the shift register.
- Flushes the shift register with zeros while capturing the bits that emerge, then presents the captured byte with an error flag comparing it against the sent byte.
- Serves as the built-in loopback/self-test sequencer sitting between a host interface and one shift-register instance.

Parameters:
DATA_WIDTH, 8, byte width; also the number of shift-register stages.
CNT_WIDTH, 5, shift counter width; must hold 2*DATA_WIDTH.

Ports:
Clk_In  input  1  clock; all flops rise-edge.
Reset_In  input  1  asynchronous, active-low reset.
Tx_Data_In  input  DATA_WIDTH  byte to send.
Tx_Valid_In  input  1  Tx_Data_In valid.
Tx_Ready_Out  output  1  controller can accept a byte.
Hold_In  input  1  pause shifting; frame progress frozen.
Rx_Data_Out  output  DATA_WIDTH  captured byte.
Rx_Valid_Out  output  1  Rx_Data_Out/Error_Out valid.
Rx_Ready_In  input  1  consumer accepts Rx_Data_Out.
Error_Out  output  1  captured byte differs from sent byte; valid with Rx_Valid_Out.
Busy_Out  output  1  frame in progress (LOAD or FLUSH).
SR_Enable_Out  output  1  drives the shift register's Enable_In.
SR_Shift_Out  output  1  drives the shift register's Shift_Data_Signal_In.
SR_Serial_Data_Out  output  1  drives the shift register's Serial_Data_In.
SR_Serial_Data_In  input  1  from the shift register's Serial_Data_Out.

Behaviour:
- Clock and reset: one clock, Clk_In. Reset_In is asynchronous and active-low.
- Reset (Reset_In=0): state=IDLE; counter=0.
  - All outputs 0 except Tx_Ready_Out=1.
  - Internal tx/rx byte registers are 0.
- Register rules:
  - All outputs are registered; no combinational input-to-output paths.
  - Tx_Ready_Out is decoded from the state register.
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - Tx_Ready_Out=1; SR_Enable_Out=0; SR_Shift_Out=0.
  - Accept edge E0 is Tx_Valid_In=1 at a rising edge. At E0:
    - latch Tx_Data_In into tx_byte;
    - counter<=0;
    - SR_Enable_Out<=1;
    - SR_Shift_Out<=!Hold_In;
    - SR_Serial_Data_Out<=Tx_Data_In[7];
    - state<=LOAD.
- Shift edge: a rising edge where SR_Shift_Out=1. Only shift edges advance the counter. At each shift edge, counter<=counter+1.
- LOAD:
  - After shift edge n (counter value n before increment), SR_Serial_Data_Out<=tx_byte[DATA_WIDTH-2-n].
  - The shift edge with counter=DATA_WIDTH-1 moves state to FLUSH and sets SR_Serial_Data_Out<=0.
- FLUSH:
  - SR_Serial_Data_Out=0.
  - At every shift edge with counter>=DATA_WIDTH, rx_byte<={rx_byte[DATA_WIDTH-2:0], SR_Serial_Data_In}. This samples the shift-register MSB before that edge's shift.
  - The shift edge with counter=2*DATA_WIDTH-1:
    - Rx_Data_Out<=final rx_byte; Rx_Valid_Out<=1;
    - Error_Out<=(final rx_byte != tx_byte);
    - SR_Shift_Out<=0; SR_Enable_Out<=0;
    - state<=DONE.
- Next SR_Shift_Out in LOAD/FLUSH = !Hold_In && (counter after this edge < 2*DATA_WIDTH).
  - Hold_In=1 sampled at edge k means no shift at edge k+1.
  - SR_Serial_Data_Out is held unchanged while paused.
- Latency with Hold_In=0: Rx_Valid_Out rises at E16 (16 cycles after E0). Each held cycle adds 1.
- DONE:
  - Rx_Valid_Out, Rx_Data_Out and Error_Out are held stable until Rx_Ready_In=1 at an edge.
  - On that edge: Rx_Valid_Out<=0, Error_Out<=0, state<=IDLE.
  - Tx_Ready_Out=0 throughout DONE.
- Busy_Out=1 exactly in LOAD/FLUSH.
- Tx_Valid_In outside IDLE is ignored; no byte is lost or queued. Rx_Ready_In outside DONE is ignored.
- Hold_In is ignored in IDLE/DONE. Hold_In asserted at E0 delays the first shift.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.
  - Stale shift-register contents are harmless, because captured bits are only those pushed in LOAD.
- SR_Serial_Data_In is sampled only at FLUSH shift edges. Z/X at other times is tolerated.

Decomposition:
- Package siso_ctrl_pkg:
  - typedef enum logic [1:0] siso_ctrl_state_t {IDLE, LOAD, FLUSH, DONE};
  - localparams SISO_DEPTH=8 and FRAME_SHIFTS=2*SISO_DEPTH.
- One sub-module, siso_bit_counter: counter with enable (shift edge), synchronous clear and terminal flags cnt_is_load_last / cnt_is_frame_last.
- Top-level testbench instantiates the controller plus the 8-bit SISO register connected back-to-back.

Test Plan:
1. Reset, send 0xA5, Hold_In=0, Rx_Ready_In=1:
   - SR_Serial_Data_Out = 1,0,1,0,0,1,0,1 then eight 0s on shift edges;
   - Rx_Valid_Out rises 16 cycles after accept; Rx_Data_Out=0xA5, Error_Out=0.
2. Send 0x3C with Hold_In=1 for 3 cycles during LOAD and 2 cycles during FLUSH:
   - no shift edges while held;
   - Rx_Valid_Out after 21 cycles; Rx_Data_Out=0x3C, Error_Out=0.
3. Send 0xA5 with the bench inverting SR_Serial_Data_In on the 3rd FLUSH capture:
   - Rx_Data_Out=0x85, Error_Out=1.
4. Send 0x00 with Rx_Ready_In=0; present Tx_Valid_In=1 with 0xFF during DONE for 10 cycles:
   - Rx_Valid_Out held, Tx_Ready_Out=0, 0xFF not accepted;
   - pulse Rx_Ready_In, then 0xFF accepted and returns 0xFF.
5. Reset_In=0 asserted mid-FLUSH (after 11 shift edges):
   - all outputs 0 asynchronously, Tx_Ready_Out=1 after release;
   - next byte 0x81 round-trips with Error_Out=0.
6. 20 random bytes with random Hold_In:
   - each Rx_Data_Out equals the sent byte, Error_Out=0;
   - latency = 16 + held shift-slot count.
